// File: rtl/if_stage_pkg.sv
// Shared constants and helpers for the MIPS instruction-fetch stage.
package if_stage_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  // sll $0,$0,0
  localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0000;
  localparam logic [5:0]  OP_J             = 6'h02;

  function automatic logic [31:0] jump_target(input logic [31:0] pc4,
                                              input logic [31:0] instr);
    return {pc4[31:28], instr[25:0], 2'b00};
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: instruction, PC+4 and valid bit.
// Flush wins over write-enable; a flushed entry is a NOP bubble.
module ifid_reg
  import if_stage_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        write_en,
  input  logic        flush,
  input  logic [31:0] fetch_instr,
  input  logic [31:0] fetch_pc4,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_q;
  logic [31:0] pc4_q;
  logic        valid_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0;
      valid_q <= 1'b0;
    end else if (write_en) begin
      instr_q <= fetch_instr;
      pc4_q   <= fetch_pc4;
      valid_q <= 1'b1;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, IF/ID register and
// wrapping fetch/bubble performance counters.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_WORD = NOP_WORD_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        PCwrite,
  input  logic        IFID_write,
  input  logic        JumpFlush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] IFID_instr,
  output logic [31:0] IFID_PC4,
  output logic        IFID_valid,
  output logic [31:0] PC,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] jump_tgt;
  logic [31:0] fetch_q, fetch_d;
  logic [31:0] bubble_q, bubble_d;
  logic        flush;

  assign pc_plus4 = pc_q + 32'd4;
  assign jump_tgt = jump_target(IFID_PC4, IFID_instr);
  // A redirect squashes the fetched word and overrides any stall.
  assign flush    = branch_taken | JumpFlush;

  always_comb begin
    pc_d     = pc_q;
    fetch_d  = fetch_q;
    bubble_d = bubble_q;
    if (branch_taken) begin
      pc_d = branch_target;
    end else if (JumpFlush) begin
      pc_d = jump_tgt;
    end else if (PCwrite) begin
      pc_d = pc_plus4;
    end
    if (flush) begin
      bubble_d = bubble_q + 32'd1;
    end else if (IFID_write) begin
      fetch_d = fetch_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      fetch_q  <= 32'h0;
      bubble_q <= 32'h0;
    end else begin
      pc_q     <= pc_d;
      fetch_q  <= fetch_d;
      bubble_q <= bubble_d;
    end
  end

  ifid_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_ifid_reg (
    .clock       (clock),
    .reset       (reset),
    .write_en    (IFID_write),
    .flush       (flush),
    .fetch_instr (imem_data),
    .fetch_pc4   (pc_plus4),
    .instr       (IFID_instr),
    .pc4         (IFID_PC4),
    .valid       (IFID_valid)
  );

  assign imem_addr    = pc_q;
  assign PC           = pc_q;
  assign fetch_count  = fetch_q;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_if_stage.sv
// Scoreboard bench for if_stage: driver pushes model-predicted state per cycle,
// a monitor pops and compares after each rising edge.
module tb_if_stage;
  import if_stage_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr, imem_data;
  logic        PCwrite = 1'b1, IFID_write = 1'b1, JumpFlush = 1'b0, branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] IFID_instr, IFID_PC4, PC, fetch_count, bubble_count;
  logic        IFID_valid;

  if_stage dut (
    .clock         (clock),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .PCwrite       (PCwrite),
    .IFID_write    (IFID_write),
    .JumpFlush     (JumpFlush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .IFID_instr    (IFID_instr),
    .IFID_PC4      (IFID_PC4),
    .IFID_valid    (IFID_valid),
    .PC            (PC),
    .fetch_count   (fetch_count),
    .bubble_count  (bubble_count)
  );

  always #5 clock = ~clock;

  // Word i holds i+1, except address 4 holds "J 0x40".
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h4) return {OP_J, 26'h40};
    return (a >> 2) + 32'd1;
  endfunction

  assign imem_data = mem_word(imem_addr);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] bc;
  } st_t;

  st_t m;
  st_t exp_q[$];
  int  checks = 0;
  int  passed = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got === want) passed++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, want);
  endtask

  task automatic model_reset();
    m = '0;
    m.pc = 32'h0;
    exp_q.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " PC"}, PC, 32'h0);
    chk({tag, " imem_addr"}, imem_addr, 32'h0);
    chk({tag, " IFID_instr"}, IFID_instr, 32'h0);
    chk({tag, " IFID_PC4"}, IFID_PC4, 32'h0);
    chk({tag, " IFID_valid"}, {31'h0, IFID_valid}, 32'h0);
    chk({tag, " fetch_count"}, fetch_count, 32'h0);
    chk({tag, " bubble_count"}, bubble_count, 32'h0);
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit pcw, input bit ifw, input bit jf, input bit bt,
                      input logic [31:0] tgt);
    st_t n;
    PCwrite = pcw; IFID_write = ifw; JumpFlush = jf; branch_taken = bt;
    branch_target = tgt;
    n = m;
    if (bt)       n.pc = tgt;
    else if (jf)  n.pc = {m.pc4[31:28], m.instr[25:0], 2'b00};
    else if (pcw) n.pc = m.pc + 32'd4;
    if (bt || jf) begin
      n.instr = 32'h0; n.pc4 = 32'h0; n.valid = 1'b0; n.bc = m.bc + 32'd1;
    end else if (ifw) begin
      n.instr = mem_word(m.pc); n.pc4 = m.pc + 32'd4; n.valid = 1'b1; n.fc = m.fc + 32'd1;
    end
    exp_q.push_back(n);
    m = n;
    @(negedge clock);
  endtask

  always @(posedge clock) begin
    st_t e;
    #1;
    if (!reset && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("sb PC", PC, e.pc);
      chk("sb imem_addr", imem_addr, e.pc);
      chk("sb IFID_instr", IFID_instr, e.instr);
      chk("sb IFID_PC4", IFID_PC4, e.pc4);
      chk("sb IFID_valid", {31'h0, IFID_valid}, {31'h0, e.valid});
      chk("sb fetch_count", fetch_count, e.fc);
      chk("sb bubble_count", bubble_count, e.bc);
    end
  end

  task automatic restart();
    reset = 1'b1;
    PCwrite = 1'b1; IFID_write = 1'b1; JumpFlush = 1'b0; branch_taken = 1'b0;
    #1;
    check_reset("reset");
    model_reset();
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    check_reset("power-on");
    @(negedge clock);
    reset = 1'b0;

    // Straight-line fetch.
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 32'h0);
    chk("plain PC", PC, 32'h10);
    chk("plain IFID_instr", IFID_instr, 32'h4);
    chk("plain IFID_PC4", IFID_PC4, 32'h10);
    chk("plain fetch_count", fetch_count, 32'd4);

    // Two-cycle stall at PC=0x8, then release.
    restart();
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    step(0, 0, 0, 0, 32'h0);
    chk("stall PC", PC, 32'h8);
    chk("stall IFID_instr", IFID_instr, {OP_J, 26'h40});
    chk("stall fetch_count", fetch_count, 32'd2);
    step(1, 1, 0, 0, 32'h0);
    chk("release IFID_instr", IFID_instr, 32'h3);

    // J 0x40 in ID with PC4=0x8.
    restart();
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 0, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    chk("jump PC", PC, 32'h100);
    chk("jump IFID_valid", {31'h0, IFID_valid}, 32'h0);
    chk("jump bubble_count", bubble_count, 32'd1);
    step(1, 1, 0, 0, 32'h0);
    chk("jump target fetch", IFID_instr, 32'h41);

    // Branch + jump + stall together: branch wins, one bubble.
    step(0, 0, 1, 1, 32'h200);
    chk("bj PC", PC, 32'h200);
    chk("bj bubble_count", bubble_count, 32'd2);

    // PC wrap.
    step(1, 1, 0, 1, 32'hFFFF_FFFC);
    step(1, 1, 0, 0, 32'h0);
    chk("wrap PC", PC, 32'h0);
    chk("wrap IFID_PC4", IFID_PC4, 32'h0);
    chk("wrap IFID_instr", IFID_instr, 32'h4000_0000);

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3, 0) != 0, $urandom_range(3, 0) != 0,
           $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0,
           $urandom & 32'hFFFF_FFFC);
    end

    // Asynchronous reset between edges.
    #3;
    restart();
    step(1, 1, 0, 0, 32'h0);
    chk("post-reset IFID_instr", IFID_instr, 32'h1);
    chk("post-reset IFID_PC4", IFID_PC4, 32'h4);
    chk("post-reset PC", PC, 32'h4);
    step(1, 1, 0, 0, 32'h0);
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage MIPS pipeline: holds the program counter, drives the instruction-memory address, and owns the IF/ID pipeline register that feeds instruction decode. It applies stall requests from the hazard unit, and redirect/flush requests from jump decode (ID) and branch resolution (EX/MEM). It also keeps two wrapping performance counters (instructions fetched, bubbles inserted).

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word-aligned)
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on flush or reset (sll $0,$0,0)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- imem_addr  out  32  byte address to instruction memory (= PC)
- imem_data  in  32  instruction word, combinational read of imem_addr
- PCwrite  in  1  0 = hold PC (load-use stall)
- IFID_write  in  1  0 = hold IF/ID register
- JumpFlush  in  1  instruction currently in ID is J
- branch_taken  in  1  taken BEQ/BNE resolved downstream
- branch_target  in  32  byte target for branch_taken
- IFID_instr  out  32  registered instruction to ID
- IFID_PC4  out  32  registered PC+4 of that instruction
- IFID_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble
- PC  out  32  current program counter
- fetch_count  out  32  instructions latched into IF/ID with valid=1
- bubble_count  out  32  cycles in which a NOP was latched by flush

## Operation
- Jump target (internal, combinational): {IFID_PC4[31:28], IFID_instr[25:0], 2'b00}.
- Next PC priority, highest first:
  - branch_taken -> branch_target
  - JumpFlush -> jump target
  - PCwrite=0 -> PC (hold)
  - otherwise PC+4 (32-bit, wraps 32'hFFFF_FFFC -> 0)
- IF/ID update priority, highest first:
  - branch_taken or JumpFlush -> instr=NOP_WORD, PC4=0, valid=0; bubble_count+1
  - IFID_write=0 -> hold all three fields
  - otherwise instr=imem_data, PC4=PC+4, valid=1; fetch_count+1
- Redirect overrides stall: when branch_taken or JumpFlush is asserted together with PCwrite=0/IFID_write=0, the redirect is applied and the stall is ignored for this stage.
- branch_taken and JumpFlush together: branch wins. The J in ID is younger and is squashed elsewhere. IF/ID is flushed once, and bubble_count increments by 1.
- Low bits of branch_target/jump target are used unmodified. Callers supply word-aligned targets. The PC is never realigned.
- Counters are 32-bit free-running and wrap to 0 with no flag.

## Timing
- Reset (asynchronous, immediate): PC=RESET_PC, IFID_instr=NOP_WORD, IFID_PC4=0, IFID_valid=0, fetch_count=0, bubble_count=0. imem_addr follows PC combinationally.
- Reset deasserted mid-operation: the first rising edge after deassertion fetches RESET_PC. Nothing from before reset survives.
- Fetch latency: the word at PC appears on IFID_instr one clock edge later.
- Redirect latency:
  - The target is on imem_addr in the cycle after the edge that samples branch_taken/JumpFlush.
  - The target instruction reaches IF/ID one edge after that.
  - Penalty is 1 bubble for J. For branches, this stage adds 1 bubble; older stages flush separately.
- Stall: each cycle with PCwrite=IFID_write=0 holds PC and IF/ID unchanged. No counter increments.
- Mismatched PCwrite/IFID_write: each control acts on its own register exactly as listed above. There is no cross-checking.
- All outputs are registered except imem_addr (=PC) and the internal jump target.

## Structure
- Shared header (constants.h): add `NOP_WORD` and the `J` opcode (already present). No new typedefs.
- Sub-module: `ifid_reg`. It holds IF/ID instr/PC4/valid with write-enable and flush inputs, and flush has priority. The parent holds the PC, the next-PC mux and the counters.

## Test plan
- Reset, no stalls, imem[i]=i+1: after 4 edges IFID_instr=4, IFID_PC4=0x10, PC=0x10, fetch_count=4.
- PCwrite=IFID_write=0 for 2 cycles at PC=0x8: PC stays 0x8, IF/ID stays unchanged, and fetch_count does not advance. Release: the next edge latches imem[0x8].
- J 0x40 in ID (IFID_PC4=0x0000_0008): next edge gives PC=0x100, IFID_valid=0, bubble_count=1. The following edge latches imem[0x100].
- branch_taken=1 (target 0x200) + JumpFlush=1 + PCwrite=0 in the same cycle: PC=0x200, a single bubble, bubble_count+1.
- PC=0xFFFF_FFFC with no stall: next PC=0, IFID_PC4=0.
- Assert reset asynchronously between edges mid-run: outputs go to reset values immediately, and the first fetch after release is from RESET_PC.
